winner_policy_param: RTL and testbench

Parametrised epsilon-greedy next-hop selector for the Q-routing node datapath, successor to the fixed 16-bit winner policy. On `start` it draws a random explore constant, reads epsilon from node memory, and then takes one of two paths. On the explore path it picks a random entry from the better-neighbour table and writes back a decayed epsilon. On the exploit path it applies two-sided hysteresis between `mybest` and `bestvalue`. New in this generation: generic widths and table geometry, in-block modulo reduction (no external address helper), zero/oversize neighbour-count handling, selectable epsilon decay mode with a floor, and an `explored` status flag.

---
 rtl/winner_policy_param_if.sv | 31 +++
 rtl/winner_policy_param.sv | 221 ++++++++++++++++++++++
 tb/tb_winner_policy_param.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/winner_policy_param_if.sv
// Memory and RNG port bundle for the epsilon-greedy next-hop selector.
// The selector is the master; node memory and the RNG sit on the slave side.
interface winner_policy_param_if #(
  parameter int WORD_WIDTH = 16,
  parameter int RNG_WIDTH  = 4
);
  logic                  en_rng;
  logic [RNG_WIDTH-1:0]  rng_out;
  logic [WORD_WIDTH-1:0] address;
  logic [WORD_WIDTH-1:0] data_in;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  wr_en;

  modport master (
    output en_rng,
    output address,
    output data_out,
    output wr_en,
    input  rng_out,
    input  data_in
  );

  modport slave (
    input  en_rng,
    input  address,
    input  data_out,
    input  wr_en,
    output rng_out,
    output data_in
  );
endinterface

// File: rtl/winner_policy_param.sv
// Parametrised epsilon-greedy next-hop selector: explore a random better
// neighbour (with epsilon decay write-back) or exploit with two-sided hysteresis.
module winner_policy_param #(
  parameter int WORD_WIDTH     = 16,
  parameter int RNG_WIDTH      = 4,
  parameter int HYST_FRAC      = 15,
  parameter int HYST_LO        = 32735,
  parameter int HYST_HI        = 32801,
  parameter int EPS_ADDR       = 32'h0000_0004,
  parameter int NBR_COUNT_ADDR = 32'h0000_068C,
  parameter int NBR_BASE_ADDR  = 32'h0000_0668,
  parameter int ENTRY_STRIDE   = 2,
  parameter int MAX_NEIGHBORS  = 16,
  parameter int INVALID_HOP    = 301,
  parameter int DECAY_MODE     = 0,
  parameter int DECAY_SHIFT    = 3,
  parameter int EPS_MIN        = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] mybest,
  input  logic [WORD_WIDTH-1:0] bestvalue,
  input  logic [WORD_WIDTH-1:0] besthop,
  input  logic [WORD_WIDTH-1:0] bestneighborID,
  input  logic [WORD_WIDTH-1:0] MY_NODE_ID,
  input  logic [WORD_WIDTH-1:0] epsilon_step,
  winner_policy_param_if.master bus,
  output logic [WORD_WIDTH-1:0] nexthop,
  output logic                  explored,
  output logic [WORD_WIDTH-1:0] which,
  output logic [WORD_WIDTH-1:0] betterNeighborCount,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = WORD_WIDTH + HYST_FRAC + 1;

  localparam logic [WORD_WIDTH-1:0] ZERO_W      = {WORD_WIDTH{1'b0}};
  localparam logic [WORD_WIDTH-1:0] EPS_ADDR_W  = WORD_WIDTH'(EPS_ADDR);
  localparam logic [WORD_WIDTH-1:0] CNT_ADDR_W  = WORD_WIDTH'(NBR_COUNT_ADDR);
  localparam logic [WORD_WIDTH-1:0] NBR_BASE_W  = WORD_WIDTH'(NBR_BASE_ADDR);
  localparam logic [WORD_WIDTH-1:0] STRIDE_W    = WORD_WIDTH'(ENTRY_STRIDE);
  localparam logic [WORD_WIDTH-1:0] MAX_NBR_W   = WORD_WIDTH'(MAX_NEIGHBORS);
  localparam logic [WORD_WIDTH-1:0] INV_HOP_W   = WORD_WIDTH'(INVALID_HOP);
  localparam logic [WORD_WIDTH-1:0] EPS_MIN_W   = WORD_WIDTH'(EPS_MIN);
  localparam logic [PW-1:0]         HYST_LO_W   = PW'(HYST_LO);
  localparam logic [PW-1:0]         HYST_HI_W   = PW'(HYST_HI);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_READY  = 4'd1,
    S_SAMPLE = 4'd2,
    S_EPS    = 4'd3,
    S_DECIDE = 4'd4,
    S_CNT    = 4'd5,
    S_MOD    = 4'd6,
    S_FETCH  = 4'd7,
    S_WRITE  = 4'd8,
    S_CMP1   = 4'd9,
    S_CMP2   = 4'd10,
    S_DONE   = 4'd11
  } state_t;

  state_t                state_r;
  logic [RNG_WIDTH-1:0]  explore_r;
  logic [WORD_WIDTH-1:0] eps_r;
  logic [WORD_WIDTH-1:0] idx_r;

  logic [WORD_WIDTH-1:0] cnt_clamped_s;
  logic [WORD_WIDTH-1:0] decay_s;
  logic [WORD_WIDTH-1:0] eps_sub_s;
  logic [WORD_WIDTH-1:0] eps_next_s;
  logic [WORD_WIDTH-1:0] entry_addr_s;
  logic [PW-1:0]         l_s;
  logic [PW-1:0]         r_lo_s;
  logic [PW-1:0]         r_hi_s;

  function automatic logic [WORD_WIDTH-1:0] sat_sub(
    input logic [WORD_WIDTH-1:0] a,
    input logic [WORD_WIDTH-1:0] b
  );
    if (a > b) begin
      return a - b;
    end else begin
      return ZERO_W;
    end
  endfunction

  // Count clamp, epsilon decay with floor, table address and hysteresis products.
  always_comb begin
    cnt_clamped_s = (bus.data_in > MAX_NBR_W) ? MAX_NBR_W : bus.data_in;
    if (DECAY_MODE == 1) begin
      decay_s = eps_r >> DECAY_SHIFT;
    end else begin
      decay_s = epsilon_step;
    end
    eps_sub_s    = sat_sub(eps_r, decay_s);
    eps_next_s   = (eps_sub_s > EPS_MIN_W) ? eps_sub_s : EPS_MIN_W;
    entry_addr_s = NBR_BASE_W + (idx_r * STRIDE_W);
    l_s          = PW'(bestvalue) << HYST_FRAC;
    r_lo_s       = PW'(mybest) * HYST_LO_W;
    r_hi_s       = PW'(mybest) * HYST_HI_W;
  end

  // Decision sequencer; every output is registered here.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r             <= S_IDLE;
      explore_r           <= {RNG_WIDTH{1'b0}};
      eps_r               <= ZERO_W;
      idx_r               <= ZERO_W;
      bus.address         <= ZERO_W;
      bus.data_out        <= ZERO_W;
      bus.wr_en           <= 1'b0;
      bus.en_rng          <= 1'b0;
      done                <= 1'b0;
      busy                <= 1'b0;
      explored            <= 1'b0;
      which               <= ZERO_W;
      betterNeighborCount <= ZERO_W;
      nexthop             <= INV_HOP_W;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (en) begin
            done     <= 1'b0;
            explored <= 1'b0;
            nexthop  <= INV_HOP_W;
            state_r  <= S_READY;
          end
        end
        S_READY: begin
          if (start) begin
            bus.en_rng  <= 1'b1;
            bus.address <= EPS_ADDR_W;
            busy        <= 1'b1;
            state_r     <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          explore_r  <= bus.rng_out;
          bus.en_rng <= 1'b0;
          state_r    <= S_EPS;
        end
        S_EPS: begin
          eps_r   <= bus.data_in;
          state_r <= S_DECIDE;
        end
        S_DECIDE: begin
          if (WORD_WIDTH'(explore_r) < eps_r) begin
            bus.en_rng  <= 1'b1;
            bus.address <= CNT_ADDR_W;
            state_r     <= S_CNT;
          end else begin
            state_r <= S_CMP1;
          end
        end
        S_CNT: begin
          bus.en_rng          <= 1'b0;
          idx_r               <= WORD_WIDTH'(bus.rng_out);
          betterNeighborCount <= cnt_clamped_s;
          if (cnt_clamped_s == ZERO_W) begin
            state_r <= S_CMP1;
          end else begin
            state_r <= S_MOD;
          end
        end
        // Modulo by repeated subtraction keeps the index reduction in-block.
        S_MOD: begin
          if (idx_r >= betterNeighborCount) begin
            idx_r <= idx_r - betterNeighborCount;
          end else begin
            which       <= idx_r;
            bus.address <= entry_addr_s;
            state_r     <= S_FETCH;
          end
        end
        S_FETCH: begin
          nexthop      <= bus.data_in;
          explored     <= 1'b1;
          bus.data_out <= eps_next_s;
          bus.address  <= EPS_ADDR_W;
          bus.wr_en    <= 1'b1;
          state_r      <= S_WRITE;
        end
        S_WRITE: begin
          bus.wr_en <= 1'b0;
          state_r   <= S_DONE;
        end
        S_CMP1: begin
          if (l_s < r_lo_s) begin
            nexthop <= besthop;
            state_r <= S_DONE;
          end else begin
            state_r <= S_CMP2;
          end
        end
        S_CMP2: begin
          if ((l_s < r_hi_s) && (bestneighborID != MY_NODE_ID)) begin
            nexthop <= besthop;
          end
          state_r <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          bus.wr_en  <= 1'b0;
          bus.en_rng <= 1'b0;
          busy       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_winner_policy_param.sv
// Directed bench for winner_policy_param: two instances (linear and shift decay)
// share stimulus, node memory and the RNG stream.
module tb_winner_policy_param;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [15:0] mybest = 16'd0;
  logic [15:0] bestvalue = 16'd0;
  logic [15:0] besthop = 16'd0;
  logic [15:0] bestneighborID = 16'd0;
  logic [15:0] MY_NODE_ID = 16'd0;
  logic [15:0] epsilon_step = 16'd0;

  logic [15:0] nh0, wh0, bnc0, nh1, wh1, bnc1;
  logic        ex0, busy0, done0, ex1, busy1, done1;

  logic [15:0] mem [0:4095];
  logic [3:0]  rng_val = 4'd0;
  logic [3:0]  rng_seq [0:1];
  int          rng_ptr = 0;

  int checks = 0;
  int failures = 0;

  int          edges, wr_cnt, wr_edge, wr_seen;
  logic [15:0] wr_addr, wd0, wd1;
  logic        done_after_en;

  winner_policy_param_if #(.WORD_WIDTH(16), .RNG_WIDTH(4)) bus0();
  winner_policy_param_if #(.WORD_WIDTH(16), .RNG_WIDTH(4)) bus1();

  assign bus0.data_in = mem[bus0.address[11:0]];
  assign bus1.data_in = mem[bus1.address[11:0]];
  assign bus0.rng_out = rng_val;
  assign bus1.rng_out = rng_val;

  winner_policy_param #(.DECAY_MODE(0)) dut0 (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .mybest(mybest), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighborID(bestneighborID), .MY_NODE_ID(MY_NODE_ID),
    .epsilon_step(epsilon_step), .bus(bus0),
    .nexthop(nh0), .explored(ex0), .which(wh0),
    .betterNeighborCount(bnc0), .busy(busy0), .done(done0)
  );

  winner_policy_param #(.DECAY_MODE(1)) dut1 (
    .clock(clock), .rst(rst), .en(en), .start(start),
    .mybest(mybest), .bestvalue(bestvalue), .besthop(besthop),
    .bestneighborID(bestneighborID), .MY_NODE_ID(MY_NODE_ID),
    .epsilon_step(epsilon_step), .bus(bus1),
    .nexthop(nh1), .explored(ex1), .which(wh1),
    .betterNeighborCount(bnc1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  // RNG model: a new value appears the cycle after each en_rng request.
  always @(negedge clock) begin
    if (start) begin
      rng_ptr = 0;
    end else if (bus0.en_rng) begin
      rng_val = rng_seq[rng_ptr[0]];
      rng_ptr = rng_ptr + 1;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Arm, start, then count edges until done while logging any write strobe.
  task automatic run_decision;
    en = 1'b1;
    tick();
    done_after_en = done0;
    en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0; wr_cnt = 0; wr_edge = 0;
    wr_addr = 16'd0; wd0 = 16'd0; wd1 = 16'd0;
    for (int i = 0; i < 60; i++) begin
      tick();
      edges++;
      if (bus0.wr_en) begin
        wr_cnt++;
        wr_edge = edges;
        wr_addr = bus0.address;
        wd0 = bus0.data_out;
        wd1 = bus1.data_out;
      end
      if (done0) break;
    end
    chk("done_reached", {31'd0, done0}, 32'd1);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 16'd0;
    rng_seq[0] = 4'd0;
    rng_seq[1] = 4'd0;

    tick(); tick();
    rst = 1'b0;
    chk("rst_nexthop", nh0, 32'd301);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_address", bus0.address, 32'd0);
    chk("rst_wr_en", {31'd0, bus0.wr_en}, 32'd0);

    // Exploit, first compare taken
    mem[12'h004] = 16'd8; rng_seq[0] = 4'd12;
    mybest = 16'd3200; bestvalue = 16'd3000; besthop = 16'd7;
    bestneighborID = 16'd4; MY_NODE_ID = 16'd2; epsilon_step = 16'd2;
    run_decision();
    chk("cmp1_edges", edges, 32'd5);
    chk("cmp1_nexthop", nh0, 32'd7);
    chk("cmp1_explored", {31'd0, ex0}, 32'd0);
    chk("cmp1_no_write", wr_cnt, 32'd0);
    chk("cmp1_busy_after", {31'd0, busy0}, 32'd0);

    // Exploit via second compare, different IDs
    bestvalue = 16'd3200;
    run_decision();
    chk("done_cleared_by_en", {31'd0, done_after_en}, 32'd0);
    chk("cmp2_edges", edges, 32'd6);
    chk("cmp2_nexthop", nh0, 32'd7);

    // Second compare, own ID -> invalid hop
    bestneighborID = 16'd2;
    run_decision();
    chk("cmp2_self_edges", edges, 32'd6);
    chk("cmp2_self_nexthop", nh0, 32'd301);

    // Explore: 13 mod 5 = 3, entry at 0x66E
    mem[12'h004] = 16'd10; mem[12'h68C] = 16'd5; mem[12'h66E] = 16'd9;
    rng_seq[0] = 4'd3; rng_seq[1] = 4'd13;
    bestneighborID = 16'd4;
    run_decision();
    chk("exp_edges", edges, 32'd10);
    chk("exp_which", wh0, 32'd3);
    chk("exp_nexthop", nh0, 32'd9);
    chk("exp_explored", {31'd0, ex0}, 32'd1);
    chk("exp_wr_cnt", wr_cnt, 32'd1);
    chk("exp_wr_addr", wr_addr, 32'h004);
    chk("exp_wr_data", wd0, 32'd8);
    chk("exp_wr_data_shift", wd1, 32'd9);
    chk("exp_wr_before_done", wr_edge, 32'd8);
    chk("exp_bnc", bnc0, 32'd5);

    // Count zero -> exploit fallback, no write
    mem[12'h68C] = 16'd0;
    rng_seq[0] = 4'd0; rng_seq[1] = 4'd6;
    bestvalue = 16'd3000;
    run_decision();
    chk("cnt0_nexthop", nh0, 32'd7);
    chk("cnt0_explored", {31'd0, ex0}, 32'd0);
    chk("cnt0_no_write", wr_cnt, 32'd0);
    chk("cnt0_bnc", bnc0, 32'd0);

    // Count 40 clamps to 16; eps 15 decays to 13 (linear) and 14 (shift)
    mem[12'h004] = 16'd15; mem[12'h68C] = 16'd40; mem[12'h672] = 16'd21;
    rng_seq[0] = 4'd0; rng_seq[1] = 4'd5;
    run_decision();
    chk("clamp_bnc", bnc0, 32'd16);
    chk("clamp_which", wh0, 32'd5);
    chk("clamp_nexthop", nh0, 32'd21);
    chk("clamp_edges", edges, 32'd8);
    chk("decay_lin_15", wd0, 32'd13);
    chk("decay_shift_15", wd1, 32'd14);

    // eps 1, step 4 saturates to 0
    mem[12'h004] = 16'd1; mem[12'h68C] = 16'd5; mem[12'h66C] = 16'd33;
    epsilon_step = 16'd4;
    rng_seq[0] = 4'd0; rng_seq[1] = 4'd2;
    run_decision();
    chk("sat_wr_data", wd0, 32'd0);
    chk("sat_nexthop", nh0, 32'd33);
    chk("sat_shift_data", wd1, 32'd1);

    // Reset while in MOD (count 1, idx 15)
    mem[12'h004] = 16'd10; mem[12'h68C] = 16'd1;
    rng_seq[0] = 4'd0; rng_seq[1] = 4'd15;
    en = 1'b1; tick(); en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mod_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy0}, 32'd0);
    chk("mrst_nexthop", nh0, 32'd301);
    chk("mrst_en_rng", {31'd0, bus0.en_rng}, 32'd0);
    chk("mrst_address", bus0.address, 32'd0);
    chk("mrst_which", wh0, 32'd0);
    chk("mrst_bnc", bnc0, 32'd0);
    chk("mrst_explored", {31'd0, ex0}, 32'd0);
    wr_seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus0.wr_en) wr_seen++;
    end
    chk("mrst_no_write", wr_seen, 32'd0);

    // Normal decision after the mid-run reset
    rng_seq[0] = 4'd12;
    run_decision();
    chk("post_rst_edges", edges, 32'd5);
    chk("post_rst_nexthop", nh0, 32'd7);

    // Reset and start together: reset wins
    en = 1'b1; tick(); en = 1'b0;
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'd0, busy0}, 32'd0);
    chk("rst_start_en_rng", {31'd0, bus0.en_rng}, 32'd0);
    tick();
    chk("rst_start_idle", {31'd0, busy0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
